// File: rtl/pkt_injector_pkg.sv
// Shared register map, CTRL bit positions and FSM state type for the MMIO packet injector.
package pkt_injector_pkg;

  localparam logic [31:0] REG_ADDR   = 32'h0000_0000;
  localparam logic [31:0] REG_NBYTES = 32'h0000_0004;
  localparam logic [31:0] REG_TIMER  = 32'h0000_0008;
  localparam logic [31:0] REG_CTRL   = 32'h0000_000C;
  localparam logic [31:0] REG_STATUS = 32'h0000_0010;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_CLR_BIT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } inj_state_t;

  // Byte enables of the final word, from the byte count's residue.
  function automatic logic [3:0] last_keep(input logic [1:0] nbytes_lo);
    logic [3:0] keep;
    case (nbytes_lo)
      2'd1:    keep = 4'b0001;
      2'd2:    keep = 4'b0011;
      2'd3:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/pkt_injector_if.sv
// NoC-side transmit stream: valid/ready words with byte enables and end-of-packet marker.
interface pkt_injector_if;
  logic [31:0] tx_data;
  logic [3:0]  tx_keep;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output tx_data, output tx_keep, output tx_last, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_keep, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/pkt_injector_regs.sv
// MMIO register window: decode, ADDR/NBYTES/TIMER storage, CTRL pulses and combinational read mux.
module pkt_injector_regs
  import pkt_injector_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        wb_in,
  input  logic        is_idle,
  input  logic        busy,
  input  logic        irq,
  input  logic [15:0] words_rem,
  output logic [31:0] data_out,
  output logic [31:0] addr_q,
  output logic [15:0] nbytes_q,
  output logic [31:0] timer_q,
  output logic        start_pulse,
  output logic        irq_clr_pulse
);

  logic        sel_addr, sel_nbytes, sel_timer, sel_ctrl, sel_status;
  logic [31:0] addr_d;
  logic [15:0] nbytes_d;
  logic [31:0] timer_d;

  assign sel_addr   = (addr_in == BASE_ADDR + REG_ADDR);
  assign sel_nbytes = (addr_in == BASE_ADDR + REG_NBYTES);
  assign sel_timer  = (addr_in == BASE_ADDR + REG_TIMER);
  assign sel_ctrl   = (addr_in == BASE_ADDR + REG_CTRL);
  assign sel_status = (addr_in == BASE_ADDR + REG_STATUS);

  assign start_pulse   = wb_in && sel_ctrl && data_in[CTRL_START_BIT];
  assign irq_clr_pulse = wb_in && sel_ctrl && data_in[CTRL_IRQ_CLR_BIT];

  // Configuration only changes while no transfer is in flight.
  always_comb begin
    addr_d   = addr_q;
    nbytes_d = nbytes_q;
    timer_d  = timer_q;
    if (wb_in && is_idle) begin
      if (sel_addr) begin
        addr_d = {data_in[31:2], 2'b00};
      end else if (sel_nbytes) begin
        nbytes_d = data_in[15:0];
      end else if (sel_timer) begin
        timer_d = data_in;
      end else begin
        addr_d = addr_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= 32'h0;
      nbytes_q <= 16'h0;
      timer_q  <= 32'h0;
    end else begin
      addr_q   <= addr_d;
      nbytes_q <= nbytes_d;
      timer_q  <= timer_d;
    end
  end

  // CTRL is write-only and unmapped addresses read as zero.
  always_comb begin
    data_out = 32'h0;
    if (sel_addr) begin
      data_out = addr_q;
    end else if (sel_nbytes) begin
      data_out = {16'h0, nbytes_q};
    end else if (sel_timer) begin
      data_out = timer_q;
    end else if (sel_status) begin
      data_out = {13'h0, words_rem, 1'b0, irq, busy};
    end else begin
      data_out = 32'h0;
    end
  end

endmodule

// File: rtl/pkt_injector_mmio.sv
// MMIO-programmed packet injector: delay, fetch NBYTES from memory word by word, stream them out, raise irq.
module pkt_injector_mmio
  import pkt_injector_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          MEM_AW    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_in,
  input  logic              wb_in,
  output logic [31:0]       data_out,
  output logic [MEM_AW-1:0] mem_addr_out,
  output logic              mem_rd_out,
  input  logic [31:0]       mem_data_in,
  pkt_injector_if.master    tx,
  output logic              irq
);

  inj_state_t        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [15:0]       nwords_q, nwords_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [3:0]        tx_keep_q, tx_keep_d;
  logic              tx_last_q, tx_last_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              entry_q, entry_d;
  logic              irq_q, irq_d;

  logic [31:0] reg_addr, reg_timer;
  logic [15:0] reg_nbytes;
  logic        start_pulse, irq_clr_pulse;
  logic [16:0] nbytes_rnd;
  logic        busy;

  assign busy       = (state_q == WAIT) || (state_q == FETCH) || (state_q == SEND);
  assign nbytes_rnd = {1'b0, reg_nbytes} + 17'd3;

  pkt_injector_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clock         (clock),
    .reset         (reset),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .wb_in         (wb_in),
    .is_idle       (state_q == IDLE),
    .busy          (busy),
    .irq           (irq_q),
    .words_rem     (nwords_q),
    .data_out      (data_out),
    .addr_q        (reg_addr),
    .nbytes_q      (reg_nbytes),
    .timer_q       (reg_timer),
    .start_pulse   (start_pulse),
    .irq_clr_pulse (irq_clr_pulse)
  );

  // Memory data arrives in the SEND entry cycle, so it is forwarded then and held afterwards.
  assign tx.tx_data    = entry_q ? mem_data_in : tx_data_q;
  assign tx.tx_keep    = tx_keep_q;
  assign tx.tx_last    = tx_last_q;
  assign tx.tx_valid   = tx_valid_q;
  assign mem_rd_out    = mem_rd_q;
  assign mem_addr_out  = mem_addr_q;
  assign irq           = irq_q;

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nwords_d   = nwords_q;
    ptr_d      = ptr_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    tx_valid_d = tx_valid_q;
    tx_keep_d  = tx_keep_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = entry_q ? mem_data_in : tx_data_q;
    entry_d    = 1'b0;
    irq_d      = irq_q;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d  = WAIT;
          cnt_d    = reg_timer;
          nwords_d = {1'b0, nbytes_rnd[16:2]};
          ptr_d    = MEM_AW'(reg_addr);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (nwords_q != 16'd0) begin
          state_d    = FETCH;
          mem_rd_d   = 1'b1;
          mem_addr_d = ptr_q;
        end else begin
          state_d = DONE;
          irq_d   = 1'b1;
        end
      end
      FETCH: begin
        state_d    = SEND;
        entry_d    = 1'b1;
        tx_valid_d = 1'b1;
        tx_last_d  = (nwords_q == 16'd1);
        tx_keep_d  = (nwords_q == 16'd1) ? last_keep(reg_nbytes[1:0]) : 4'b1111;
      end
      SEND: begin
        if (tx.tx_ready) begin
          ptr_d      = ptr_q + MEM_AW'(32'd4);
          nwords_d   = nwords_q - 16'd1;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          if (nwords_q == 16'd1) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end else begin
            state_d    = FETCH;
            mem_rd_d   = 1'b1;
            mem_addr_d = ptr_q + MEM_AW'(32'd4);
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        if (irq_clr_pulse) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        irq_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 32'h0;
      nwords_q   <= 16'h0;
      ptr_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      tx_valid_q <= 1'b0;
      tx_keep_q  <= 4'h0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= 32'h0;
      entry_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nwords_q   <= nwords_d;
      ptr_q      <= ptr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_keep_q  <= tx_keep_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
      entry_q    <= entry_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: doc/pkt_injector_mmio.md
# pkt_injector_mmio

Memory-mapped packet injector that sits on the CPU's MMIO bus as a responder. It is the target end of the CPU configuration sequence that programs ADDR, NBYTES and TIMER and then writes CTRL.START. On start, it waits TIMER cycles, fetches NBYTES from local memory as 32-bit words, and streams them onto the NoC-side tx interface. On completion it raises a level `irq` to the CPU until software clears it.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: MMIO base of the register window.
- `MEM_AW`, default 32: memory address width.
- `clock`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `addr_in`  in  32: MMIO address from CPU.
- `data_in`  in  32: MMIO write data.
- `wb_in`  in  1: MMIO write strobe; one write per cycle it is high.
- `data_out`  out  32: MMIO read data, combinational on `addr_in`.
- `mem_addr_out`  out  MEM_AW: word-aligned memory read address.
- `mem_rd_out`  out  1: memory read request.
- `mem_data_in`  in  32: read data, valid exactly 1 cycle after `mem_rd_out`.
- `tx_data`  out  32: stream word.
- `tx_keep`  out  4: byte enables; bit0 = byte at lowest address.
- `tx_last`  out  1: final word of packet.
- `tx_valid`  out  1: word valid.
- `tx_ready`  in  1: sink accepts when `tx_valid && tx_ready`.
- `irq`  out  1: completion interrupt, level.

## Operation
- Registers (offset from BASE_ADDR):
  - 0x0 ADDR (32b, start address, low 2 bits forced 0).
  - 0x4 NBYTES (16b used).
  - 0x8 TIMER (32b delay).
  - 0xC CTRL (write-only: bit0 START, bit1 IRQ_CLR).
  - 0x10 STATUS (read: bit0 busy, bit1 irq, bits[18:3] words remaining).
- Reads of other addresses and of CTRL return 0. Writes to unmapped addresses are ignored.
- Writes to ADDR, NBYTES and TIMER are ignored unless the state is IDLE.
- FSM states are IDLE, WAIT, FETCH, SEND and DONE.
- IDLE → WAIT: on a CTRL write with bit0=1.
  - Latch cnt=TIMER and nwords=(NBYTES+3)>>2.
  - Latch ptr=ADDR.
- WAIT:
  - If cnt==0, go to FETCH if nwords≠0, otherwise to DONE.
  - Otherwise decrement cnt.
- FETCH: assert `mem_rd_out` with `mem_addr_out`=ptr for 1 cycle, then go to SEND.
- SEND, entry cycle: capture `mem_data_in` into `tx_data` and assert `tx_valid`.
  - `tx_last` = (nwords==1).
  - `tx_keep` = 4'b1111, except on the last word: NBYTES[1:0]=1/2/3 → 0001/0011/0111.
- SEND, on handshake: ptr+=4 and nwords−=1. If it was the last word go to DONE, else go to FETCH.
- `tx_data`, `tx_keep` and `tx_last` stay stable while `tx_valid && !tx_ready`.
- DONE: `irq`=1. A CTRL write with bit1=1 clears `irq` and goes to IDLE; bit0 in that same write is ignored.
- START while not in IDLE is ignored. IRQ_CLR outside DONE is ignored.
- NBYTES=0 still honours TIMER, then raises `irq` without any transfer.
- ptr wraps modulo 2^MEM_AW.

## Timing
- Reset (async) forces:
  - state=IDLE.
  - All registers, counters and ptr to 0.
  - `irq`, `tx_valid`, `tx_last`, `mem_rd_out` to 0; `tx_keep`, `tx_data` and `mem_addr_out` to 0.
- Reset mid-transfer drops `tx_valid` immediately with no tx_last.
- A START write in cycle t puts WAIT in t+1. FETCH occurs at t+2+TIMER.
- First `tx_valid` at t+3+TIMER, assuming `tx_ready` is held high.
- Steady state is 2 cycles per word (FETCH + SEND) with `tx_ready` high.
- `irq` rises the cycle after the last handshake. It falls the cycle after the IRQ_CLR write.
- `data_out` reflects register state as of the current cycle; no read latency.

## Structure
- Package `pkt_injector_pkg`:
  - Register offsets REG_ADDR/REG_NBYTES/REG_TIMER/REG_CTRL/REG_STATUS.
  - CTRL bit indices.
  - State enum `inj_state_t`.
- Sub-module `pkt_injector_regs` contains:
  - MMIO decode, the ADDR/NBYTES/TIMER registers and STATUS read mux.
  - START and IRQ_CLR single-cycle pulses.
- The top level holds the FSM, counters and stream datapath.

## Test plan
- Program ADDR=0x100, NBYTES=12, TIMER=30, START with `tx_ready`=1 → first `tx_valid` 33 cycles after START. Reads at 0x100/0x104/0x108, 3 words, `tx_last` on the 3rd, `tx_keep`=1111, `irq`=1 and STATUS=0x2.
- NBYTES=7, TIMER=0 → 2 words; second has `tx_keep`=0111 and `tx_last`=1.
- `tx_ready` held low 5 cycles on word 2 → `tx_data`/`tx_keep`/`tx_last` stable, no extra `mem_rd_out`; transfer resumes on ready.
- NBYTES=0, TIMER=4 → no `mem_rd_out` or `tx_valid`; `irq` rises 6 cycles after START. Writing CTRL=0x3 clears `irq`, returns to IDLE and does not restart.
- Write NBYTES=99 and START during WAIT → both ignored; the original transfer completes unchanged.
- Assert `reset` during SEND → `tx_valid`/`irq` drop asynchronously and registers read 0. A new START after reset runs normally.
